// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart_core slice.
//   - TX/RX FSM state encodings
//   - parity mode constants (PARITY_NONE/EVEN/ODD)
//   - oversampling constants (OVERSAMPLE ticks per bit, MID_SAMPLE tick offset)
//   - parity_bit(): parity of a data word, zero-extended to 9 bits
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_SAMPLE  = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Zero-extension does not change the XOR, so any width up to 9 fits.
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversample tick generator.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (counter -> 0)
//   restart     - reload the counter now, realigning the tick phase
//   baud_div    - clk cycles per tick; 0 behaves as 1
//   tick        - one-clk pulse each time the counter reaches 0
// A new baud_div takes effect at the next reload.
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] reload;

  always_comb begin
    reload = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
    tick   = (cnt == '0) && !restart;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: single-clock UART transceiver with runtime baud divisor.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   loopback        - (only with UART_LOOPBACK_EN) RX takes serial_out instead of serial_in
//   baud_div        - clk cycles per 16x oversample tick (0 behaves as 1)
//   tx_valid/tx_data/tx_ready - bus-side transmit handshake
//   serial_out      - TX line, idles high
//   serial_in       - RX line, asynchronous
//   rx_data/rx_valid/rx_parity_err/rx_frame_err - received word, 1-cycle valid, held flags
// Optional feature macro: UART_LOOPBACK_EN.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef UART_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  // ---------------- TX ----------------
  tx_state_t             tx_state, tx_state_next;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par;
  logic [3:0]            tx_tick_cnt;
  logic [3:0]            tx_bit_idx;
  logic                  tx_tick;
  logic                  tx_accept;
  logic                  tx_bit_end;

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tx_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (tx_accept),
    .baud_div (baud_div),
    .tick     (tx_tick)
  );

  always_comb begin
    tx_state_next = tx_state;
    tx_ready      = (tx_state == TX_IDLE);
    tx_accept     = tx_valid && tx_ready;
    tx_bit_end    = tx_tick && (tx_tick_cnt == LAST_TICK);
    serial_out    = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (tx_accept) tx_state_next = TX_START;
      end
      TX_START: begin
        serial_out = 1'b0;
        if (tx_bit_end) tx_state_next = TX_DATA;
      end
      TX_DATA: begin
        serial_out = tx_shift[0];
        if (tx_bit_end && tx_bit_idx == LAST_DATA)
          tx_state_next = (PARITY_MODE == PARITY_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: begin
        serial_out = tx_par;
        if (tx_bit_end) tx_state_next = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end && tx_bit_idx == LAST_STOP) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // Tick and bit counters restart on every state change, so each state
  // begins on a fresh bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
    end else begin
      tx_state <= tx_state_next;
      if (tx_accept) begin
        tx_shift <= tx_data;
        tx_par   <= parity_bit(9'(tx_data), PARITY_MODE);
      end else if (tx_state == TX_DATA && tx_bit_end) begin
        tx_shift <= tx_shift >> 1;
      end
      if (tx_state_next != tx_state) begin
        tx_tick_cnt <= '0;
        tx_bit_idx  <= '0;
      end else begin
        if (tx_tick)    tx_tick_cnt <= tx_tick_cnt + 4'd1;
        if (tx_bit_end) tx_bit_idx  <= tx_bit_idx + 4'd1;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t             rx_state, rx_state_next;
  logic                  rx_src;
  logic                  rx_sync1, rx_sync2, rx_prev;
  logic                  rx_fall;
  logic                  rx_tick;
  logic                  rx_restart;
  logic                  rx_sample;
  logic                  rx_stop_done;
  logic [3:0]            rx_tick_cnt;
  logic [3:0]            rx_bit_idx;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_par_acc;
  logic                  rx_frame_acc;

  always_comb begin
`ifdef UART_LOOPBACK_EN
    rx_src = loopback ? serial_out : serial_in;
`else
    rx_src = serial_in;
`endif
  end

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_rx_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (rx_restart),
    .baud_div (baud_div),
    .tick     (rx_tick)
  );

  always_comb begin
    rx_state_next = rx_state;
    rx_fall       = rx_prev && !rx_sync2;
    rx_restart    = (rx_state == RX_IDLE) && rx_fall;
    rx_sample     = rx_tick &&
                    (rx_tick_cnt == ((rx_state == RX_START) ? MID_TICK : LAST_TICK));
    rx_stop_done  = (rx_state == RX_STOP) && rx_sample && (rx_bit_idx == LAST_STOP);
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) rx_state_next = RX_START;
      end
      RX_START: begin
        if (rx_sample) rx_state_next = rx_sync2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_sample && rx_bit_idx == LAST_DATA)
          rx_state_next = (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: begin
        if (rx_sample) rx_state_next = RX_STOP;
      end
      RX_STOP: begin
        // A frame error usually means a break; hold off until the line recovers.
        if (rx_stop_done)
          rx_state_next = (rx_frame_acc || !rx_sync2) ? RX_WAIT_HIGH : RX_IDLE;
      end
      RX_WAIT_HIGH: begin
        if (rx_sync2) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1      <= 1'b1;
      rx_sync2      <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_tick_cnt   <= '0;
      rx_bit_idx    <= '0;
      rx_shift      <= '0;
      rx_par_acc    <= 1'b0;
      rx_frame_acc  <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_sync1 <= rx_src;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_state <= rx_state_next;
      rx_valid <= rx_stop_done;

      if (rx_state_next != rx_state) begin
        rx_tick_cnt <= '0;
        rx_bit_idx  <= '0;
      end else begin
        if (rx_tick)   rx_tick_cnt <= rx_tick_cnt + 4'd1;
        if (rx_sample) rx_bit_idx  <= rx_bit_idx + 4'd1;
      end

      case (rx_state)
        RX_IDLE: begin
          rx_par_acc   <= 1'b0;
          rx_frame_acc <= 1'b0;
        end
        RX_DATA: begin
          if (rx_sample) rx_shift <= {rx_sync2, rx_shift[DATA_WIDTH-1:1]};
        end
        RX_PARITY: begin
          if (rx_sample) rx_par_acc <= rx_sync2 ^ parity_bit(9'(rx_shift), PARITY_MODE);
        end
        RX_STOP: begin
          if (rx_sample && !rx_sync2) rx_frame_acc <= 1'b1;
        end
        default: ;
      endcase

      if (rx_stop_done) begin
        rx_data       <= rx_shift;
        rx_parity_err <= rx_par_acc;
        rx_frame_err  <= rx_frame_acc || !rx_sync2;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic        serial_out;
  logic        serial_in = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_parity_err;
  logic        rx_frame_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned vcnt = 0;
  logic [7:0]  cap_data = '0;
  logic        cap_perr = 1'b0;
  logic        cap_ferr = 1'b0;

  always #5 clk = ~clk;

  uart_core #(
    .DATA_WIDTH  (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .DIV_WIDTH   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef UART_LOOPBACK_EN
    .loopback      (1'b0),
`endif
    .baud_div      (baud_div),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .serial_out    (serial_out),
    .serial_in     (serial_in),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt++;
      cap_data = rx_data;
      cap_perr = rx_parity_err;
      cap_ferr = rx_frame_err;
    end
  end

`ifdef UART_LOOPBACK_EN
  logic       lb_tx_valid = 1'b0;
  logic [7:0] lb_tx_data = '0;
  logic       lb_tx_ready, lb_serial_out;
  logic [7:0] lb_rx_data;
  logic       lb_rx_valid, lb_rx_perr, lb_rx_ferr;
  int unsigned lb_vcnt = 0;

  uart_core #(
    .DATA_WIDTH  (8),
    .PARITY_MODE (2),
    .STOP_BITS   (1),
    .DIV_WIDTH   (16)
  ) dut_lb (
    .clk           (clk),
    .reset         (reset),
    .loopback      (1'b1),
    .baud_div      (baud_div),
    .tx_valid      (lb_tx_valid),
    .tx_data       (lb_tx_data),
    .tx_ready      (lb_tx_ready),
    .serial_out    (lb_serial_out),
    .serial_in     (1'b0),
    .rx_data       (lb_rx_data),
    .rx_valid      (lb_rx_valid),
    .rx_parity_err (lb_rx_perr),
    .rx_frame_err  (lb_rx_ferr)
  );

  always @(negedge clk) if (lb_rx_valid) lb_vcnt++;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // frame[0] is the start bit, frame[10] the stop bit.
  task automatic tx_check(input string tag, input logic [7:0] data,
                          input logic [10:0] frame, input int unsigned cpb);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = data;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, "_ready_low"}, tx_ready, 1'b0);
    wait_neg(cpb / 2);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_bit%0d", tag, i), serial_out, frame[i]);
      if (i < 10) wait_neg(cpb);
    end
    wait_neg(cpb / 2 - 1);
    check({tag, "_ready_last_low"}, tx_ready, 1'b0);
    wait_neg(1);
    check({tag, "_ready_back"}, tx_ready, 1'b1);
  endtask

  task automatic rx_drive(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk);
    serial_in = 1'b0;
    wait_neg(64);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      wait_neg(64);
    end
    serial_in = par;
    wait_neg(64);
    serial_in = stop;
    wait_neg(64);
    serial_in = 1'b1;
    wait_neg(64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_neg(4);
    reset = 1'b0;
    wait_neg(1);

    check("rst_tx_ready",   tx_ready,      1'b1);
    check("rst_serial_out", serial_out,    1'b1);
    check("rst_rx_data",    rx_data,       8'h00);
    check("rst_rx_valid",   rx_valid,      1'b0);
    check("rst_perr",       rx_parity_err, 1'b0);
    check("rst_ferr",       rx_frame_err,  1'b0);

    // 0xA5, even parity 0
    tx_check("txA5", 8'hA5, 11'b1_0_10100101_0, 64);

    // divisor 0 behaves as 1: 16 clk per bit; 0x0F parity 0
    baud_div = 16'd0;
    tx_check("txdiv0", 8'h0F, 11'b1_0_00001111_0, 16);
    baud_div = 16'd4;

    // good frame 0x3C
    vcnt = 0;
    rx_drive(8'h3C, 1'b0, 1'b1);
    check("rx3C_count", vcnt, 1);
    check("rx3C_data",  cap_data, 8'h3C);
    check("rx3C_perr",  cap_perr, 1'b0);
    check("rx3C_ferr",  cap_ferr, 1'b0);

    // false start: low for 4 ticks only
    vcnt = 0;
    @(negedge clk);
    serial_in = 1'b0;
    wait_neg(16);
    serial_in = 1'b1;
    wait_neg(200);
    check("false_start_count", vcnt, 0);
    rx_drive(8'hC3, 1'b0, 1'b1);
    check("rxC3_count", vcnt, 1);
    check("rxC3_data",  cap_data, 8'hC3);

    // inverted parity
    vcnt = 0;
    rx_drive(8'h3C, 1'b1, 1'b1);
    check("rxpar_count", vcnt, 1);
    check("rxpar_data",  cap_data, 8'h3C);
    check("rxpar_perr",  cap_perr, 1'b1);
    check("rxpar_ferr",  cap_ferr, 1'b0);
    wait_neg(300);
    check("rxpar_hold",  rx_parity_err, 1'b1);

    // stop bit low, then line held low (break) before recovering
    vcnt = 0;
    @(negedge clk);
    serial_in = 1'b0;
    wait_neg(64);
    for (int i = 0; i < 8; i++) begin
      serial_in = (i >= 2 && i <= 5);
      wait_neg(64);
    end
    serial_in = 1'b0;
    wait_neg(64);
    wait_neg(300);
    check("rxbrk_count", vcnt, 1);
    check("rxbrk_data",  cap_data, 8'h3C);
    check("rxbrk_perr",  cap_perr, 1'b0);
    check("rxbrk_ferr",  cap_ferr, 1'b1);
    serial_in = 1'b1;
    wait_neg(100);
    check("rxbrk_no_retrigger", vcnt, 1);

    // clean frame clears both flags
    vcnt = 0;
    rx_drive(8'h5A, 1'b0, 1'b1);
    check("rx5A_count", vcnt, 1);
    check("rx5A_data",  cap_data, 8'h5A);
    check("rx5A_perr",  rx_parity_err, 1'b0);
    check("rx5A_ferr",  rx_frame_err, 1'b0);

    // reset in the middle of a 0xFF frame
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_neg(4 * 64 + 32);
    check("txFF_busy", tx_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_serial_out", serial_out, 1'b1);
    check("midrst_tx_ready",   tx_ready,   1'b1);
    tx_check("tx01", 8'h01, 11'b1_1_00000001_0, 64);

    // tx_valid together with reset: word is not taken
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    reset    = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    reset    = 1'b0;
    check("rstwin_ready", tx_ready, 1'b1);
    wait_neg(10);
    check("rstwin_serial_out", serial_out, 1'b1);
    check("rstwin_ready_later", tx_ready, 1'b1);

`ifdef UART_LOOPBACK_EN
    // odd parity loopback, serial_in of that instance tied low
    lb_vcnt = 0;
    @(negedge clk);
    lb_tx_valid = 1'b1;
    lb_tx_data  = 8'h80;
    @(negedge clk);
    lb_tx_valid = 1'b0;
    wait_neg(12 * 64);
    check("lb_count", lb_vcnt, 1);
    check("lb_data",  lb_rx_data, 8'h80);
    check("lb_perr",  lb_rx_perr, 1'b0);
    check("lb_ferr",  lb_rx_ferr, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
